// File: rtl/lab2_proc_int_mul_iter_unit.sv
// Iterative shift-add multiplier: one partial-product step per cycle, fixed NBITS-cycle
// latency, val/rdy request and response handshakes, low NBITS of a*b returned.
module lab2_proc_int_mul_iter_unit #(
  parameter int NBITS = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_val,
  output logic               req_rdy,
  input  logic [2*NBITS-1:0] req_msg,
  output logic               resp_val,
  input  logic               resp_rdy,
  output logic [NBITS-1:0]   resp_msg
);

  localparam int CW = $clog2(NBITS);
  localparam logic [CW-1:0] LAST_COUNT = CW'(NBITS - 1);
  localparam logic [CW-1:0] COUNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [NBITS-1:0] a_q, a_d;
  logic [NBITS-1:0] b_q, b_d;
  logic [NBITS-1:0] result_q, result_d;
  logic [CW-1:0]    count_q, count_d;
  logic             req_rdy_q, req_rdy_d;
  logic             resp_val_q, resp_val_d;

  // Next-state and datapath: operand capture in IDLE, one shift-add step per CALC cycle.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    count_d  = count_q;
    case (state_q)
      IDLE: begin
        if (req_val) begin
          a_d      = req_msg[2*NBITS-1:NBITS];
          b_d      = req_msg[NBITS-1:0];
          result_d = {NBITS{1'b0}};
          count_d  = {CW{1'b0}};
          state_d  = CALC;
        end else begin
          state_d  = IDLE;
        end
      end
      CALC: begin
        if (b_q[0]) begin
          result_d = result_q + a_q;
        end else begin
          result_d = result_q;
        end
        a_d     = a_q << 1;
        b_d     = b_q >> 1;
        count_d = count_q + COUNT_ONE;
        // No early exit on b==0 so the latency stays fixed.
        if (count_q == LAST_COUNT) begin
          state_d = DONE;
        end else begin
          state_d = CALC;
        end
      end
      DONE: begin
        if (resp_rdy) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    req_rdy_d  = (state_d == IDLE);
    resp_val_d = (state_d == DONE);
  end

  // State, datapath and handshake-output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      a_q        <= {NBITS{1'b0}};
      b_q        <= {NBITS{1'b0}};
      result_q   <= {NBITS{1'b0}};
      count_q    <= {CW{1'b0}};
      req_rdy_q  <= 1'b1;
      resp_val_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      result_q   <= result_d;
      count_q    <= count_d;
      req_rdy_q  <= req_rdy_d;
      resp_val_q <= resp_val_d;
    end
  end

  assign req_rdy  = req_rdy_q;
  assign resp_val = resp_val_q;
  assign resp_msg = result_q;

endmodule
